// File: rtl/grf_wr_arbiter.sv
// Single-write-port arbiter merging the W-stage writeback (P0) with two multi-cycle
// result sources (P1, P2) onto the GRF's registered write port, with bounded starvation.
module grf_wr_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_we,
    input  logic [4:0]  p0_a3,
    input  logic [31:0] p0_wd,
    input  logic [31:0] p0_pc,
    output logic        p0_ready,

    input  logic        p1_valid,
    input  logic [4:0]  p1_a3,
    input  logic [31:0] p1_wd,
    input  logic [31:0] p1_pc,
    output logic        p1_ready,

    input  logic        p2_valid,
    input  logic [4:0]  p2_a3,
    input  logic [31:0] p2_wd,
    input  logic [31:0] p2_pc,
    output logic        p2_ready,

    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc,

    output logic        stall_req
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        SrcNone,
        SrcP0,
        SrcP1,
        SrcP2
    } src_e;

    src_e        src;
    src_e        rr_pick;
    logic        p0_active;
    logic        p0_null;
    logic        sec_any;
    logic        sec_grant;

    // rr_p2_q = 1 means P2 is the preferred secondary (rr_ptr = 2).
    logic        rr_p2_q;
    logic        rr_p2_d;
    logic [3:0]  wait_cnt_q;
    logic [3:0]  wait_cnt_d;

    logic [4:0]  win_a3;
    logic [31:0] win_wd;
    logic [31:0] win_pc;
    logic        grf_we_d;
    logic [4:0]  grf_a3_d;
    logic [31:0] grf_wd_d;
    logic [31:0] grf_pc_d;

    assign stall_req = (wait_cnt_q == Limit);

    // Request decode and grant selection.
    always_comb begin
        p0_active = p0_we && (p0_a3 != 5'd0);
        p0_null   = p0_we && (p0_a3 == 5'd0);
        sec_any   = p1_valid || p2_valid;

        if (rr_p2_q) begin
            rr_pick = p2_valid ? SrcP2 : SrcP1;
        end else begin
            rr_pick = p1_valid ? SrcP1 : SrcP2;
        end

        src = SrcNone;
        if (reset) begin
            src = SrcNone;
        end else if (stall_req && sec_any) begin
            src = rr_pick;
        end else if (p0_active) begin
            src = SrcP0;
        end else if (sec_any) begin
            src = rr_pick;
        end

        sec_grant = (src == SrcP1) || (src == SrcP2);
        // A write to r0 from P0 is absorbed without taking the slot.
        p0_ready  = !reset && ((src == SrcP0) || p0_null);
        p1_ready  = (src == SrcP1);
        p2_ready  = (src == SrcP2);
    end

    // Winner data mux.
    always_comb begin
        win_a3 = 5'd0;
        win_wd = 32'd0;
        win_pc = 32'd0;
        case (src)
            SrcP0: begin
                win_a3 = p0_a3;
                win_wd = p0_wd;
                win_pc = p0_pc;
            end
            SrcP1: begin
                win_a3 = p1_a3;
                win_wd = p1_wd;
                win_pc = p1_pc;
            end
            SrcP2: begin
                win_a3 = p2_a3;
                win_wd = p2_wd;
                win_pc = p2_pc;
            end
            default: begin
                win_a3 = 5'd0;
                win_wd = 32'd0;
                win_pc = 32'd0;
            end
        endcase
    end

    // Next-state for output slot, round-robin pointer and starvation counter.
    always_comb begin
        grf_we_d   = 1'b0;
        grf_a3_d   = grf_a3;
        grf_wd_d   = grf_wd;
        grf_pc_d   = grf_pc;
        rr_p2_d    = rr_p2_q;
        wait_cnt_d = wait_cnt_q;

        if (src != SrcNone) begin
            grf_we_d = (win_a3 != 5'd0);
            grf_a3_d = win_a3;
            grf_wd_d = win_wd;
            grf_pc_d = win_pc;
        end

        if (src == SrcP1) begin
            rr_p2_d = 1'b1;
        end else if (src == SrcP2) begin
            rr_p2_d = 1'b0;
        end

        if (sec_grant || !sec_any) begin
            wait_cnt_d = 4'd0;
        end else if (src == SrcP0) begin
            wait_cnt_d = (wait_cnt_q == Limit) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grf_we     <= 1'b0;
            grf_a3     <= 5'd0;
            grf_wd     <= 32'd0;
            grf_pc     <= 32'd0;
            rr_p2_q    <= 1'b0;
            wait_cnt_q <= 4'd0;
        end else begin
            grf_we     <= grf_we_d;
            grf_a3     <= grf_a3_d;
            grf_wd     <= grf_wd_d;
            grf_pc     <= grf_pc_d;
            rr_p2_q    <= rr_p2_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Randomized and directed bench for grf_wr_arbiter against a cycle-level behavioural model.
module tb_grf_wr_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_we, p1_valid, p2_valid;
    logic [4:0]  p0_a3, p1_a3, p2_a3;
    logic [31:0] p0_wd, p1_wd, p2_wd;
    logic [31:0] p0_pc, p1_pc, p2_pc;
    logic        p0_ready, p1_ready, p2_ready;
    logic        grf_we, stall_req;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pc;

    always #5 clk = ~clk;

    grf_wr_arbiter #(.STARVE_LIMIT(L)) dut (
        .clk(clk), .reset(reset),
        .p0_we(p0_we), .p0_a3(p0_a3), .p0_wd(p0_wd), .p0_pc(p0_pc), .p0_ready(p0_ready),
        .p1_valid(p1_valid), .p1_a3(p1_a3), .p1_wd(p1_wd), .p1_pc(p1_pc), .p1_ready(p1_ready),
        .p2_valid(p2_valid), .p2_a3(p2_a3), .p2_wd(p2_wd), .p2_pc(p2_pc), .p2_ready(p2_ready),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .stall_req(stall_req)
    );

    // Model state: what the registered outputs must be, preferred port, lost-cycle count.
    int          m_pref;
    int          m_cnt;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd, m_pc;
    bit          g0, g1, g2;
    int          n_vec, n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare one cycle at the negative edge, advance the model, return just after posedge.
    task automatic step();
        int win;
        int rr;
        bit sec, p0a, p0z, stall, e0;
        @(negedge clk);
        sec   = p1_valid || p2_valid;
        p0a   = p0_we && (p0_a3 != 0);
        p0z   = p0_we && (p0_a3 == 0);
        stall = (m_cnt == L);
        rr    = (m_pref == 1) ? (p1_valid ? 1 : 2) : (p2_valid ? 2 : 1);
        if (reset)             win = -1;
        else if (stall && sec) win = rr;
        else if (p0a)          win = 0;
        else if (sec)          win = rr;
        else                   win = -1;
        e0 = !reset && (win == 0 || p0z);

        chk("p0_ready", {31'd0, p0_ready}, {31'd0, e0});
        chk("p1_ready", {31'd0, p1_ready}, (win == 1) ? 1 : 0);
        chk("p2_ready", {31'd0, p2_ready}, (win == 2) ? 1 : 0);
        chk("stall_req", {31'd0, stall_req}, stall ? 1 : 0);
        chk("grf_we", {31'd0, grf_we}, {31'd0, m_we});
        chk("grf_a3", {27'd0, grf_a3}, {27'd0, m_a3});
        chk("grf_wd", grf_wd, m_wd);
        chk("grf_pc", grf_pc, m_pc);

        g0 = e0;
        g1 = (win == 1);
        g2 = (win == 2);

        if (reset) begin
            m_we = 0; m_a3 = 0; m_wd = 0; m_pc = 0; m_pref = 1; m_cnt = 0;
        end else begin
            m_we = 0;
            if (win == 0) begin m_a3 = p0_a3; m_wd = p0_wd; m_pc = p0_pc; end
            if (win == 1) begin m_a3 = p1_a3; m_wd = p1_wd; m_pc = p1_pc; end
            if (win == 2) begin m_a3 = p2_a3; m_wd = p2_wd; m_pc = p2_pc; end
            if (win >= 0) m_we = (m_a3 != 0);
            if (win == 1) m_pref = 2;
            if (win == 2) m_pref = 1;
            if (win == 0 && sec) m_cnt = (m_cnt < L) ? m_cnt + 1 : L;
            else m_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_we = 0; p0_a3 = 0; p0_wd = 0; p0_pc = 0;
        p1_valid = 0; p1_a3 = 0; p1_wd = 0; p1_pc = 0;
        p2_valid = 0; p2_a3 = 0; p2_wd = 0; p2_pc = 0;
    endtask

    task automatic do_reset(input int n);
        idle_inputs();
        reset = 1;
        repeat (n) step();
        reset = 0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_pref = 1; m_cnt = 0; m_we = 0; m_a3 = 0; m_wd = 0; m_pc = 0;
        idle_inputs();
        reset = 1;
        @(posedge clk);
        #1;
        do_reset(2);

        // Idle after reset.
        chk("rst_a3", {27'd0, grf_a3}, 0);
        chk("rst_wd", grf_wd, 0);
        chk("rst_stall", {31'd0, stall_req}, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_we", {31'd0, grf_we}, 0);
        end

        // Single P1 write, P1 preferred from reset.
        p1_valid = 1; p1_a3 = 5; p1_wd = 32'h1234; p1_pc = 32'h100;
        #1;
        chk("p1_first_ready", {31'd0, p1_ready}, 1);
        step();
        chk("p1_first_we", {31'd0, grf_we}, 1);
        chk("p1_first_a3", {27'd0, grf_a3}, 5);
        chk("p1_first_wd", grf_wd, 32'h1234);
        idle_inputs();

        // Both secondaries held, P0 idle: strict alternation starting at P1.
        do_reset(1);
        p1_valid = 1; p1_a3 = 1; p1_wd = 11; p1_pc = 32'h10;
        p2_valid = 1; p2_a3 = 2; p2_wd = 22; p2_pc = 32'h20;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_p1", {31'd0, p1_ready}, (k % 2 == 0) ? 1 : 0);
            chk("rr_p2", {31'd0, p2_ready}, (k % 2 == 1) ? 1 : 0);
            step();
            chk("rr_a3", {27'd0, grf_a3}, (k % 2 == 0) ? 1 : 2);
        end
        idle_inputs();

        // P0 busy every cycle starves P2 for exactly L cycles.
        do_reset(1);
        p0_we = 1; p0_a3 = 7; p0_wd = 32'h77; p0_pc = 32'h700;
        p2_valid = 1; p2_a3 = 3; p2_wd = 32'h33; p2_pc = 32'h300;
        for (int c = 1; c <= 6; c++) begin
            #1;
            if (c <= 4) begin
                chk("starve_p0", {31'd0, p0_ready}, 1);
                chk("starve_p2", {31'd0, p2_ready}, 0);
                chk("starve_stall", {31'd0, stall_req}, 0);
            end else if (c == 5) begin
                chk("flip_stall", {31'd0, stall_req}, 1);
                chk("flip_p2", {31'd0, p2_ready}, 1);
                chk("flip_p0", {31'd0, p0_ready}, 0);
            end else begin
                chk("resume_stall", {31'd0, stall_req}, 0);
                chk("resume_p0", {31'd0, p0_ready}, 1);
            end
            step();
            if (c == 5) p2_valid = 0;
        end
        idle_inputs();

        // Writes to r0 are consumed without producing a GRF write.
        do_reset(1);
        p0_we = 1; p0_a3 = 0; p0_wd = 32'hdead;
        p1_valid = 1; p1_a3 = 0; p1_wd = 5;
        #1;
        chk("r0_p0_ready", {31'd0, p0_ready}, 1);
        chk("r0_p1_ready", {31'd0, p1_ready}, 1);
        step();
        chk("r0_we_a", {31'd0, grf_we}, 0);
        idle_inputs();
        step();
        chk("r0_we_b", {31'd0, grf_we}, 0);

        // Reset right after a grant discards the slot and restores P1 preference.
        do_reset(1);
        p1_valid = 1; p1_a3 = 9; p1_wd = 32'h99; p1_pc = 32'h900;
        step();
        chk("pre_rst_we", {31'd0, grf_we}, 1);
        chk("pre_rst_a3", {27'd0, grf_a3}, 9);
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
        chk("post_rst_we", {31'd0, grf_we}, 0);
        chk("post_rst_a3", {27'd0, grf_a3}, 0);
        p1_valid = 1; p1_a3 = 4; p2_valid = 1; p2_a3 = 6;
        #1;
        chk("post_rst_rr", {31'd0, p1_ready}, 1);
        step();
        idle_inputs();

        // Random traffic; requesters hold until accepted.
        do_reset(1);
        g0 = 1; g1 = 1; g2 = 1;
        for (int i = 0; i < 3000; i++) begin
            if (!p0_we || g0) begin
                p0_we = ($urandom_range(9, 0) < 6);
                p0_a3 = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
                p0_wd = $urandom;
                p0_pc = $urandom;
            end
            if (!p1_valid || g1) begin
                p1_valid = ($urandom_range(99, 0) < 35);
                p1_a3 = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
                p1_wd = $urandom;
                p1_pc = $urandom;
            end
            if (!p2_valid || g2) begin
                p2_valid = ($urandom_range(99, 0) < 35);
                p2_a3 = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
                p2_wd = $urandom;
                p2_pc = $urandom;
            end
            reset = ($urandom_range(99, 0) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/grf_wr_arbiter.md
# grf_wr_arbiter

Single-write-port arbiter in front of the 32x32 general register file. It merges three writeback sources into the file's one write port: the pipeline W stage (P0), and two multi-cycle result sources (P1, P2), for example a mult/div unit and a slow load return. The output stage is registered, and the GRF `WE/A3/WD/pc` inputs are driven directly from it. A bounded-starvation counter raises `stall_req` to the hazard unit so that secondary sources cannot be locked out indefinitely.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive cycles a waiting secondary request may lose to P0 before priority flips. Legal range 1..15.
- Reset is synchronous and active-high on `reset`; the clock is `clk`.
- `clk` in 1: clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `p0_we` in 1: P0 write request.
- `p0_a3` in 5: P0 destination register.
- `p0_wd` in 32: P0 write data.
- `p0_pc` in 32: P0 instruction address.
- `p0_ready` out 1: P0 write accepted this cycle.
- `p1_valid`, `p2_valid` in 1: secondary write requests.
- `p1_a3`, `p2_a3` in 5: secondary destination registers.
- `p1_wd`, `p2_wd` in 32: secondary write data.
- `p1_pc`, `p2_pc` in 32: secondary instruction addresses.
- `p1_ready`, `p2_ready` out 1: secondary request accepted this cycle (combinational grant).
- `grf_we` out 1: registered write enable to the GRF.
- `grf_a3` out 5: registered destination register.
- `grf_wd` out 32: registered write data.
- `grf_pc` out 32: registered instruction address.
- `stall_req` out 1: request to the hazard unit to freeze W.

## Operation
- P0 request is active when `p0_we=1` and `p0_a3≠0`. When `p0_we=1` and `p0_a3=0`, `p0_ready=1`, no slot is consumed, and no write is produced.
- Secondary request n is active when `pn_valid=1`.
- Grant rules are evaluated every cycle, in order:
  1. If `stall_req=1` and any secondary request is active, the secondary wins, `p0_ready=0`, and P0 must hold its request stable.
  2. Otherwise, if P0 is active, P0 wins and `p1_ready=p2_ready=0`.
  3. Otherwise the secondaries are arbitrated round-robin. `rr_ptr∈{1,2}` marks the preferred port. The preferred port is granted if active, otherwise the other port.
- `p0_ready=1` whenever P0 is active and not blocked by rule 1.
- `rr_ptr` updates only on a secondary grant: a grant to P1 sets it to 2, a grant to P2 sets it to 1.
- A granted secondary with `a3=0` is consumed: ready=1, `rr_ptr` and the counter update as for any grant, and the output slot issues `grf_we=0`.
- Output register:
  - When a grant occurs, the winner's `a3/wd/pc` is captured at the edge, and `grf_we=1` if `a3≠0`.
  - With no grant, `grf_we=0` and `a3/wd/pc` hold their previous values.
- Starvation counter `wait_cnt`, 4 bits, saturating at `STARVE_LIMIT`:
  - Increments when any secondary request is active and P0 wins.
  - Clears to 0 on any secondary grant, or when no secondary request is active.
  - Otherwise holds.
- `stall_req = (wait_cnt == STARVE_LIMIT)`, decoded combinationally from the registered counter.

## Timing
- Reset values: `grf_we=0`, `grf_a3=0`, `grf_wd=0`, `grf_pc=0`, `rr_ptr=1`, `wait_cnt=0`, `stall_req=0`.
- While `reset=1`, all ready outputs are forced to 0.
- A reset asserted mid-stream discards any grant in that cycle. Requesters must re-present after reset.
- Grant-to-write latency is 1 cycle: a request accepted in cycle t appears on `grf_*` in cycle t+1, and the GRF commits it at the end of cycle t+1.
- Ready outputs are combinational from the valid inputs and state. Requesters must hold valid, a3, wd and pc stable until ready=1. Dropping valid before ready is illegal.
- Throughput is one write per cycle. Back-to-back grants to the same port are allowed only when the other secondary is idle.
- `stall_req` rises in the cycle after the `STARVE_LIMIT`-th consecutive P0 win over a waiting secondary. It falls in the cycle after that secondary is granted, so it is high for exactly 1 cycle when the secondary is waiting.
- When P0 and both secondaries are simultaneously active under `stall_req`, the round-robin decides between P1 and P2.
- Read ports are unaffected. Read-after-write forwarding for the in-flight `grf_*` slot is the hazard unit's responsibility.

## Test plan
- After reset, with no requests: all outputs are 0 and `grf_we` stays 0 for 10 cycles.
- `p1_valid` with a3=5, wd=0x1234, and P1 preferred (reset `rr_ptr=1`): `p1_ready=1` in the same cycle; next cycle `grf_we=1`, `grf_a3=5`, `grf_wd=0x1234`.
- `p1_valid` and `p2_valid` held continuously with P0 idle: grants alternate P1, P2, P1, P2.
- P0 active every cycle with `p2_valid` held and `STARVE_LIMIT=4`:
  - P0 wins 4 cycles.
  - `stall_req=1` on cycle 5, where P2 is granted and `p0_ready=0`.
  - `stall_req=0` on cycle 6 and P0 resumes.
- `p0_we=1` with a3=0 and `p1_valid` with a3=0:
  - `p0_ready=1` immediately with no slot consumed, so P1 is granted in the same cycle.
  - `grf_we` never rises.
- P1 granted in cycle t, then `reset` in cycle t+1: `grf_we=0` in cycle t+2 and `rr_ptr` returns to 1.
